// File: rtl/reg_share_arbiter_pkg.sv
// Shared definitions for the round-robin register-share arbiter:
// state encoding and default sizing.
package reg_share_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNTW  = 8;

  typedef enum logic {
    IDLE  = ST_IDLE,
    GRANT = ST_GRANT
  } state_t;

endpackage

// File: rtl/reg_share_arbiter_if.sv
// Requester-facing bus of the register-share arbiter: request/data lanes in,
// grant, owner, shared register and debug counter out.
interface reg_share_arbiter_if
  import reg_share_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNTW  = DEF_CNTW
);

  localparam int OW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [OW-1:0]         owner;
  logic [WIDTH-1:0]      q;
  logic                  busy;
  logic [CNTW-1:0]       wr_count;

  modport master (
    output req, wdata,
    input  gnt, owner, q, busy, wr_count
  );

  modport slave (
    input  req, wdata,
    output gnt, owner, q, busy, wr_count
  );

endinterface

// File: rtl/reg_share_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester at or after owner+1,
// wrapping modulo NREQ.
module rr_pick
  import reg_share_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] owner,
  output logic                    found,
  output logic [$clog2(NREQ)-1:0] winner
);

  localparam int OW = $clog2(NREQ);

  logic [OW:0] idx;

  // Walk farthest-to-nearest so the candidate closest to owner+1 is written last.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = {1'b0, owner} + (OW+1)'(k);
      if (idx >= (OW+1)'(NREQ)) idx = idx - (OW+1)'(NREQ);
      if (req[idx[OW-1:0]]) begin
        found  = 1'b1;
        winner = idx[OW-1:0];
      end
    end
  end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter sequencing one-cycle grants into a single shared
// WIDTH-bit register, with owner tracking and a saturating write counter.
module reg_share_arbiter
  import reg_share_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNTW  = DEF_CNTW
) (
  input  logic              clk,
  input  logic              rst,
  reg_share_arbiter_if.slave bus
);

  localparam int OW = $clog2(NREQ);

  state_t            state, state_nxt;
  logic              found;
  logic [OW-1:0]     pick;
  logic [OW-1:0]     win_r;
  logic [OW-1:0]     owner_r;
  logic [NREQ-1:0]   gnt_r;
  logic [WIDTH-1:0]  q_r;
  logic [WIDTH-1:0]  lane;
  logic [CNTW-1:0]   cnt_r;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (bus.req),
    .owner  (owner_r),
    .found  (found),
    .winner (pick)
  );

  always_comb begin
    lane = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_r == OW'(i)) lane = bus.wdata[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // GRANT is always a single cycle, which forces an IDLE gap between grants.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = GRANT;
      GRANT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_r   <= '0;
      win_r   <= '0;
      owner_r <= OW'(NREQ-1);
      q_r     <= '0;
      cnt_r   <= '0;
    end else begin
      gnt_r <= '0;
      if (state == IDLE && found) begin
        gnt_r <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
        win_r <= pick;
      end
      if (state == GRANT) begin
        q_r     <= lane;
        owner_r <= win_r;
        cnt_r   <= sat_inc(cnt_r);
      end
    end
  end

  assign bus.gnt      = gnt_r;
  assign bus.owner    = owner_r;
  assign bus.q        = q_r;
  assign bus.busy     = (state == GRANT);
  assign bus.wr_count = cnt_r;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Bench for reg_share_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_reg_share_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int CNTW  = 8;
  localparam int CMAX  = (1 << CNTW) - 1;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  bit   mon_on = 1'b0;

  always #5 clk = ~clk;

  reg_share_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(CNTW)) ifc ();

  reg_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_lane(input int i, input logic [WIDTH-1:0] v);
    ifc.wdata[i*WIDTH +: WIDTH] = v;
  endtask

  // Behavioural model: a pending grant index (-1 = none) resolved on the next edge.
  int             m_pend  = -1;
  int             m_owner = NREQ - 1;
  int             m_cnt   = 0;
  logic [WIDTH-1:0] m_q   = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_pend  = -1;
      m_owner = NREQ - 1;
      m_cnt   = 0;
      m_q     = '0;
    end else if (m_pend >= 0) begin
      m_q     = ifc.wdata[m_pend*WIDTH +: WIDTH];
      m_owner = m_pend;
      m_cnt   = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      m_pend  = -1;
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        int idx;
        idx = (m_owner + k) % NREQ;
        if (m_pend < 0 && ifc.req[idx]) m_pend = idx;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      logic [NREQ-1:0] eg;
      eg = '0;
      if (m_pend >= 0) eg[m_pend] = 1'b1;
      chk("model_gnt",   ifc.gnt,      eg);
      chk("model_busy",  ifc.busy,     m_pend >= 0);
      chk("model_q",     ifc.q,        m_q);
      chk("model_owner", ifc.owner,    m_owner);
      chk("model_cnt",   ifc.wr_count, m_cnt);
    end
  end

  initial begin
    rst       = 1'b1;
    ifc.req   = 4'($urandom);
    ifc.wdata = $urandom;

    // Reset held for two cycles
    @(negedge clk);
    mon_on = 1'b1;
    @(negedge clk);
    chk("rst_q", ifc.q, 0);
    chk("rst_gnt", ifc.gnt, 0);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_cnt", ifc.wr_count, 0);
    chk("rst_owner", ifc.owner, 3);

    // Single requester
    rst = 1'b0; ifc.req = 4'b0100; ifc.wdata = '0; set_lane(2, 8'hA5);
    @(negedge clk);
    chk("single_gnt", ifc.gnt, 4'b0100);
    chk("single_busy", ifc.busy, 1);
    @(negedge clk);
    chk("single_q", ifc.q, 8'hA5);
    chk("single_owner", ifc.owner, 2);
    chk("single_cnt", ifc.wr_count, 1);
    chk("single_gap", ifc.gnt, 0);
    @(negedge clk);
    chk("single_regnt", ifc.gnt, 4'b0100);
    ifc.req = 4'b0000;
    @(negedge clk);
    chk("single_cnt2", ifc.wr_count, 2);

    // Rotation with all requesters active
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; ifc.req = 4'b1111;
    set_lane(0, 8'h11); set_lane(1, 8'h22); set_lane(2, 8'h33); set_lane(3, 8'h44);
    for (int g = 0; g < 4; g++) begin
      logic [7:0] ev;
      ev = 8'h11 * (g + 1);
      @(negedge clk);
      chk("rot_gnt", ifc.gnt, 4'b0001 << g);
      @(negedge clk);
      chk("rot_q", ifc.q, ev);
    end
    chk("rot_cnt", ifc.wr_count, 4);
    @(negedge clk);
    chk("rot_wrap", ifc.gnt, 4'b0001);
    ifc.req = 4'b0000;
    @(negedge clk);

    // Fairness after skip: make owner 1, then request 0 and 1
    ifc.req = 4'b0010;
    @(negedge clk);
    chk("fair_g1", ifc.gnt, 4'b0010);
    ifc.req = 4'b0011;
    @(negedge clk);
    chk("fair_owner", ifc.owner, 1);
    @(negedge clk);
    chk("fair_gnt", ifc.gnt, 4'b0001);
    ifc.req = 4'b0000;
    @(negedge clk);

    // Request dropped during its grant cycle
    ifc.req = 4'b0001; set_lane(0, 8'h00);
    @(negedge clk);
    chk("drop_gnt", ifc.gnt, 4'b0001);
    ifc.req = 4'b0000; set_lane(0, 8'h5C);
    @(negedge clk);
    chk("drop_q", ifc.q, 8'h5C);
    @(negedge clk);
    chk("drop_idle_gnt", ifc.gnt, 0);
    chk("drop_idle_busy", ifc.busy, 0);

    // Reset during GRANT aborts the write
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; ifc.req = 4'b0100; set_lane(2, 8'h00);
    @(negedge clk);
    chk("rstg_gnt", ifc.gnt, 4'b0100);
    rst = 1'b1; set_lane(2, 8'hFF);
    @(negedge clk);
    chk("rstg_q", ifc.q, 0);
    chk("rstg_gnt0", ifc.gnt, 0);
    chk("rstg_cnt", ifc.wr_count, 0);
    rst = 1'b0; ifc.req = 4'b0110;
    @(negedge clk);
    chk("rstg_first", ifc.gnt, 4'b0010);

    // Counter saturation under continuous traffic
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; ifc.req = 4'b1111;
    repeat (530) @(negedge clk);
    chk("sat_cnt", ifc.wr_count, CMAX);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 2000; c++) begin
      ifc.req   = 4'($urandom_range(0, 15));
      ifc.wdata = $urandom;
      rst       = ($urandom_range(0, 63) == 0);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_share_arbiter.md
# reg_share_arbiter

Round-robin arbiter that shares one WIDTH-bit D-register between NREQ requesters. Each requester raises a request, receives a one-cycle grant, and its write data is loaded into the shared register on the closing edge of the grant cycle. The block sits between independent producers and the single storage flop bank, sequencing every load so that no two writers ever collide. It also exposes the current owner and a saturating write counter for debug.

## Interface
- NREQ, 4: number of requesters, 2..8.
- WIDTH, 8: width of the shared register and of each write-data lane.
- CNTW, 8: width of the write counter.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  request bit per requester, level-sensitive.
- wdata  in  NREQ*WIDTH  write lanes; lane i is bits [i*WIDTH +: WIDTH].
- gnt  out  NREQ  one-hot grant, registered; all zero when idle.
- owner  out  $clog2(NREQ)  index of the last granted requester.
- q  out  WIDTH  shared register contents.
- busy  out  1  high while state is GRANT.
- wr_count  out  CNTW  number of completed writes, saturating at all-ones.

## Operation
- FSM with two states:
  - IDLE: gnt = 0, busy = 0. On a clock edge with any req bit set, pick a winner and go to GRANT with gnt[winner] = 1. Otherwise stay in IDLE.
  - GRANT: lasts exactly one cycle. On the closing edge, q <= wdata lane[winner], owner <= winner, and wr_count increments unless it is saturated. Then return to IDLE.
- Winner selection: search starts at owner+1 and wraps modulo NREQ. The first requester found with req set wins. This is round-robin with no starvation.
- Only one grant is issued per visit to GRANT. Back-to-back GRANT is illegal; every grant is followed by at least one IDLE cycle.
- Once granted, the write is committed. If req[winner] drops during GRANT, the write still occurs using the wdata lane sampled on that closing edge.
- Requirements on requesters: hold req high until gnt is seen, and present valid data on the wdata lane during the gnt cycle. A requester that keeps req high after its grant is simply re-queued.
- Changes to req during GRANT do not affect the current grant. They are only evaluated in the following IDLE cycle.
- wr_count saturates at 2^CNTW-1 and does not wrap.

## Timing
- Reset values: state IDLE, gnt 0, busy 0, q 0, wr_count 0, owner NREQ-1. Because the search starts at owner+1, requester 0 has first priority after reset.
- Grant latency: req sampled high at edge n gives gnt high during cycle n..n+1. The matching q update is visible after edge n+1.
- Maximum throughput: one write per 2 cycles. With all requesters held high, grants rotate 0,1,2,…,NREQ-1,0, spaced 2 cycles apart.
- Reset asserted during GRANT: the pending write is aborted, and on that edge every output takes its reset value. rst has priority over all other inputs.
- Single continuous requester: it receives a grant every 2 cycles.
- Write data sampling: wdata lanes are read only on the closing edge of GRANT, so setup is relative to that edge only.

## Structure
- Shared package (reg_share_pkg) holds:
  - state encoding constants: ST_IDLE = 1'b0, ST_GRANT = 1'b1;
  - the default NREQ and WIDTH values.
- One sub-module, rr_pick: a combinational round-robin selector taking (req, owner) and producing (found, winner index). It is instantiated once.
- The shared storage is a plain WIDTH-bit D-register with synchronous reset, inferred in the top module. It is not a separate module.

## Test plan
- Reset: hold rst for 2 cycles with arbitrary req/wdata -> q = 0, gnt = 0, busy = 0, wr_count = 0, owner = 3 (NREQ = 4).
- Single requester: req = 4'b0100, lane2 = 8'hA5 -> gnt = 4'b0100 for one cycle, then q = 8'hA5, owner = 2, wr_count = 1. The grant repeats every 2 cycles while req is held.
- Rotation: req = 4'b1111, lanes = 11/22/33/44 -> grant order 0,1,2,3,0. After 4 grants wr_count = 4, and q follows 11, 22, 33, 44.
- Fairness after skip: owner = 1, req = 4'b0011 -> next grant goes to 0 (wraps past 2 and 3), not 1.
- Request dropped mid-grant: req0 high, granted, then req0 low during the gnt cycle with lane0 = 8'h5C -> q = 8'h5C anyway, and FSM returns to IDLE with no further grant.
- Reset during GRANT: assert rst in the gnt cycle with lane = 8'hFF -> q stays 0, gnt = 0, wr_count = 0. The first grant after release goes to the lowest-index active requester.
